mono_ro_emulator: RTL

Chip-side model of the MONOPIX2 serial readout: the transmitting end of the Freeze/Read/TokOut/DataOut link consumed by mono_data_rx.
- Buffers hits written by a stimulus source.
- Raises the token, honours the Freeze/Read handshake and shifts out each 27-bit hit word serially.
- Used in simulation benches and as an FPGA loopback source for exercising the receive path without a sensor.

---
 rtl/mono_ro_emulator.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mono_ro_emulator.sv
// Transmit side of the MONOPIX2 Freeze/Read/TokOut/DataOut readout link.
// Hits are buffered in a FIFO and shifted out MSB first, one 27-bit word per Read edge.
module mono_ro_emulator #(
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic                 HIT_WRITE,
    input  logic [5:0]           HIT_COL,
    input  logic [8:0]           HIT_ROW,
    input  logic [5:0]           HIT_LE,
    input  logic [5:0]           HIT_TE,
    output logic                 HIT_FULL,
    input  logic                 FREEZE,
    input  logic                 READ,
    output logic                 TOK_OUT,
    output logic                 DATA_OUT,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] HIT_COUNT,
    output logic [7:0]           LOST_CNT
);

    localparam int                   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [4:0]           LAST_BIT = 5'd26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;

    logic [26:0]          mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_s;
    logic [CNT_WIDTH-1:0] frozen_r;
    logic [CNT_WIDTH-1:0] frozen_s;
    logic                 freeze_d_r;
    logic                 read_d_r;
    state_t               state_r;
    state_t               state_s;
    logic [26:0]          shreg_r;
    logic [26:0]          shreg_s;
    logic [4:0]           bit_cnt_r;
    logic [4:0]           bit_cnt_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 tok_r;
    logic                 tok_s;
    logic                 full_r;
    logic                 full_s;
    logic [7:0]           lost_r;
    logic [7:0]           lost_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 read_edge_s;
    logic [26:0]          hit_word_s;

    assign hit_word_s  = {HIT_COL, HIT_ROW, HIT_LE, HIT_TE};
    // Fullness is judged on the registered flag, so a same-cycle pop never rescues a push.
    assign push_s      = HIT_WRITE & ENABLE & ~full_r;
    assign drop_s      = HIT_WRITE & ENABLE & full_r;
    assign read_edge_s = READ & ~read_d_r;

    assign HIT_FULL  = full_r;
    assign TOK_OUT   = tok_r;
    assign DATA_OUT  = shreg_r[26];
    assign BUSY      = busy_r;
    assign HIT_COUNT = count_r;
    assign LOST_CNT  = lost_r;

    // Readout FSM: load the head word on an accepted Read edge, then shift 27 bits.
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_cnt_s = bit_cnt_r;
        busy_s    = busy_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read_edge_s && ENABLE && FREEZE && (frozen_r != '0)) begin
                    pop_s     = 1'b1;
                    shreg_s   = mem_r[rd_ptr_r];
                    bit_cnt_s = 5'd0;
                    busy_s    = 1'b1;
                    state_s   = ST_SHIFT;
                end else begin
                    shreg_s   = 27'd0;
                    bit_cnt_s = 5'd0;
                    busy_s    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == LAST_BIT) begin
                    shreg_s   = 27'd0;
                    bit_cnt_s = 5'd0;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    shreg_s   = {shreg_r[25:0], 1'b0};
                    bit_cnt_s = bit_cnt_r + 5'd1;
                    busy_s    = 1'b1;
                end
            end
            default: begin
                shreg_s   = 27'd0;
                bit_cnt_s = 5'd0;
                busy_s    = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // Occupancy, frozen-set size, token and loss counter next values.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_WIDTH'(1);
            2'b01:   count_s = count_r - CNT_WIDTH'(1);
            default: count_s = count_r;
        endcase

        if (!FREEZE) begin
            frozen_s = '0;
        end else if (!freeze_d_r) begin
            frozen_s = count_r;
        end else if (pop_s) begin
            frozen_s = frozen_r - CNT_WIDTH'(1);
        end else begin
            frozen_s = frozen_r;
        end

        full_s = (count_s == DEPTH_C);

        if (FREEZE) begin
            tok_s = (frozen_s != '0);
        end else begin
            tok_s = (count_s != '0);
        end

        if (drop_s && (lost_r != 8'd255)) begin
            lost_s = lost_r + 8'd1;
        end else begin
            lost_s = lost_r;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            frozen_r   <= '0;
            freeze_d_r <= 1'b0;
            read_d_r   <= 1'b0;
            state_r    <= ST_IDLE;
            shreg_r    <= 27'd0;
            bit_cnt_r  <= 5'd0;
            busy_r     <= 1'b0;
            tok_r      <= 1'b0;
            full_r     <= 1'b0;
            lost_r     <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_s;
            frozen_r   <= frozen_s;
            freeze_d_r <= FREEZE;
            read_d_r   <= READ;
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            bit_cnt_r  <= bit_cnt_s;
            busy_r     <= busy_s;
            tok_r      <= tok_s;
            full_r     <= full_s;
            lost_r     <= lost_s;
        end
    end

    // Hit storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= hit_word_s;
        end
    end

endmodule
